mips_fetch_stage: RTL and testbench

Instruction-fetch stage of the single-clock pipelined MIPS core, sitting directly upstream of decode. Owns the program counter, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register. Honours stall and flush requests from the hazard unit and redirects from the branch/jump resolver, and keeps a retired-fetch counter for the testbench.

---
 rtl/mips_fetch_stage.sv | 110 +++++++++++
 tb/tb_mips_fetch_stage.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, addresses imem, and
// registers the fetched word into the IF/ID bundle for decode.
//
// Ports:
//   inp_clk, inp_rst        - clock, synchronous active-high reset
//   stall, flush            - hazard-unit hold / bubble requests
//   redirect, redirect_pc   - taken branch/jump and its target
//   imem_addr, imem_rdata   - instruction memory (combinational read)
//   if_id_instr/pc4/valid   - registered IF/ID bundle
//   misalign                - sticky flag for a non-word-aligned target
//   fetch_count             - valid words loaded into IF/ID
module mips_fetch_stage #(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0,
    parameter logic [31:0]          NOP_WORD = 32'h0000_0000
) (
    input  logic              inp_clk,
    input  logic              inp_rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc4,
    output logic              if_id_valid,
    output logic              misalign,
    output logic [31:0]       fetch_count
);

    typedef struct packed {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] pc4;
        logic              valid;
    } if_id_t;

    localparam if_id_t BUBBLE = '{
        instr: NOP_WORD,
        pc4:   '0,
        valid: 1'b0
    };

    logic [ADDR_W-1:0] pc_q, pc_d;
    if_id_t            if_id_q, if_id_d;
    logic              misalign_q, misalign_d;
    logic [31:0]       count_q, count_d;
    logic [ADDR_W-1:0] pc_plus4;
    logic              load_word;

    // Wraps modulo 2^ADDR_W by construction.
    assign pc_plus4 = pc_q + ADDR_W'(4);

    // A real word enters IF/ID only when neither killed nor held.
    assign load_word = !flush && !stall;

    always_comb begin
        pc_d       = pc_q;
        if_id_d    = if_id_q;
        misalign_d = misalign_q;
        count_d    = count_q;

        // Redirect beats stall so a resolved branch is never lost.
        if (redirect) begin
            pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
        end else if (!stall) begin
            pc_d = pc_plus4;
        end

        if (flush) begin
            if_id_d = BUBBLE;
        end else if (!stall) begin
            if_id_d = '{
                instr: imem_rdata,
                pc4:   pc_plus4,
                valid: 1'b1
            };
        end

        if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end

        if (load_word) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge inp_clk) begin
        if (inp_rst) begin
            pc_q       <= RESET_PC;
            if_id_q    <= BUBBLE;
            misalign_q <= 1'b0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            if_id_q    <= if_id_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_instr = if_id_q.instr;
    assign if_id_pc4   = if_id_q.pc4;
    assign if_id_valid = if_id_q.valid;
    assign misalign    = misalign_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Self-checking bench for mips_fetch_stage against a behavioural
// fetch model; a second instance covers PC wrap at the top of memory.
module tb_mips_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        misalign;
    logic [31:0] fetch_count;

    logic        rst_w = 1'b1;
    logic        zero_w = 1'b0;
    logic [31:0] zpc_w = '0;
    logic [31:0] addr_w, rdata_w, instr_w, pc4_w, cnt_w;
    logic        valid_w, mis_w;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid, m_mis;

    always #5 clk = ~clk;

    // Instruction memory: word i holds 0x2000_0000 + i.
    assign imem_rdata = 32'h2000_0000 + (imem_addr >> 2);
    assign rdata_w    = 32'h2000_0000 + (addr_w >> 2);

    mips_fetch_stage u_dut (
        .inp_clk     (clk),
        .inp_rst     (rst),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .misalign    (misalign),
        .fetch_count (fetch_count)
    );

    mips_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .inp_clk     (clk),
        .inp_rst     (rst_w),
        .stall       (zero_w),
        .flush       (zero_w),
        .redirect    (zero_w),
        .redirect_pc (zpc_w),
        .imem_addr   (addr_w),
        .imem_rdata  (rdata_w),
        .if_id_instr (instr_w),
        .if_id_pc4   (pc4_w),
        .if_id_valid (valid_w),
        .misalign    (mis_w),
        .fetch_count (cnt_w)
    );

    // One rising edge of the fetch stage, stated in plain terms.
    task automatic model_edge();
        logic [31:0] word;
        word = 32'h2000_0000 + (m_pc >> 2);
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
            m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
        end else begin
            if (redirect && redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
            if (flush) begin
                m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            end else if (!stall) begin
                m_instr = word; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                m_cnt = m_cnt + 32'd1;
            end
            if (redirect) m_pc = redirect_pc & ~32'd3;
            else if (!stall) m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic cycle(input logic r, input logic s,
                         input logic f, input logic rd,
                         input logic [31:0] rpc);
        rst = r; stall = s; flush = f;
        redirect = rd; redirect_pc = rpc;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checks += 6;
        if (imem_addr !== 32'h0) begin
            errors++; $display("FAIL rst_addr got=%h exp=0", imem_addr);
        end
        if (if_id_instr !== 32'h0) begin
            errors++; $display("FAIL rst_instr got=%h exp=0", if_id_instr);
        end
        if (if_id_pc4 !== 32'h0) begin
            errors++; $display("FAIL rst_pc4 got=%h exp=0", if_id_pc4);
        end
        if (if_id_valid !== 1'b0) begin
            errors++; $display("FAIL rst_valid got=%b exp=0", if_id_valid);
        end
        if (misalign !== 1'b0) begin
            errors++; $display("FAIL rst_mis got=%b exp=0", misalign);
        end
        if (fetch_count !== 32'h0) begin
            errors++; $display("FAIL rst_cnt got=%h exp=0", fetch_count);
        end
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            checks += 4;
            if (imem_addr !== 32'(4 * (i + 1))) begin
                errors++;
                $display("FAIL run_addr got=%h exp=%h", imem_addr, 4 * (i + 1));
            end
            if (if_id_instr !== 32'h2000_0000 + 32'(i)) begin
                errors++;
                $display("FAIL run_instr got=%h exp=%h", if_id_instr,
                         32'h2000_0000 + 32'(i));
            end
            if (if_id_pc4 !== 32'(4 * (i + 1)) || if_id_valid !== 1'b1) begin
                errors++;
                $display("FAIL run_pc4 got=%h/%b exp=%h/1", if_id_pc4,
                         if_id_valid, 4 * (i + 1));
            end
            if (fetch_count !== 32'(i + 1)) begin
                errors++;
                $display("FAIL run_cnt got=%0d exp=%0d", fetch_count, i + 1);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] a, ins, p4, c;
        a = m_pc; ins = m_instr; p4 = m_pc4; c = m_cnt;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            checks += 4;
            if (imem_addr !== a) begin
                errors++; $display("FAIL stall_addr got=%h exp=%h", imem_addr, a);
            end
            if (if_id_instr !== ins) begin
                errors++; $display("FAIL stall_instr got=%h exp=%h", if_id_instr, ins);
            end
            if (if_id_pc4 !== p4) begin
                errors++; $display("FAIL stall_pc4 got=%h exp=%h", if_id_pc4, p4);
            end
            if (fetch_count !== c) begin
                errors++; $display("FAIL stall_cnt got=%0d exp=%0d", fetch_count, c);
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (imem_addr !== a + 32'd4) begin
            errors++; $display("FAIL unstall_addr got=%h exp=%h", imem_addr, a + 4);
        end
    endtask

    task automatic test_redirect_flush();
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
        checks += 3;
        if (imem_addr !== 32'h40) begin
            errors++; $display("FAIL rf_addr got=%h exp=40", imem_addr);
        end
        if (if_id_valid !== 1'b0) begin
            errors++; $display("FAIL rf_valid got=%b exp=0", if_id_valid);
        end
        if (if_id_instr !== 32'h0) begin
            errors++; $display("FAIL rf_instr got=%h exp=0", if_id_instr);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checks += 2;
        if (if_id_instr !== 32'h2000_0010) begin
            errors++; $display("FAIL rf_next_instr got=%h exp=20000010", if_id_instr);
        end
        if (if_id_pc4 !== 32'h44) begin
            errors++; $display("FAIL rf_next_pc4 got=%h exp=44", if_id_pc4);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] ins, p4;
        ins = m_instr; p4 = m_pc4;
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h43);
        checks += 4;
        if (imem_addr !== 32'h40) begin
            errors++; $display("FAIL mis_addr got=%h exp=40", imem_addr);
        end
        if (misalign !== 1'b1) begin
            errors++; $display("FAIL mis_set got=%b exp=1", misalign);
        end
        if (if_id_instr !== ins || if_id_pc4 !== p4) begin
            errors++;
            $display("FAIL mis_hold got=%h/%h exp=%h/%h", if_id_instr,
                     if_id_pc4, ins, p4);
        end
        if (fetch_count !== m_cnt) begin
            errors++; $display("FAIL mis_cnt got=%0d exp=%0d", fetch_count, m_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            checks++;
            if (misalign !== 1'b1) begin
                errors++; $display("FAIL mis_sticky got=%b exp=1", misalign);
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (fetch_count !== 32'd5) begin
            errors++; $display("FAIL mid_pre_cnt got=%0d exp=5", fetch_count);
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h81);
        checks += 3;
        if (imem_addr !== 32'h0) begin
            errors++; $display("FAIL mid_addr got=%h exp=0", imem_addr);
        end
        if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0) begin
            errors++;
            $display("FAIL mid_ifid got=%h/%h/%b exp=0/0/0", if_id_instr,
                     if_id_pc4, if_id_valid);
        end
        if (misalign !== 1'b0 || fetch_count !== 32'h0) begin
            errors++;
            $display("FAIL mid_state got=%b/%0d exp=0/0", misalign, fetch_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0),
                  32'($urandom_range(0, 255)));
            checks += 6;
            if (imem_addr !== m_pc) begin
                errors++; $display("FAIL rnd_addr got=%h exp=%h", imem_addr, m_pc);
            end
            if (if_id_instr !== m_instr) begin
                errors++; $display("FAIL rnd_instr got=%h exp=%h", if_id_instr, m_instr);
            end
            if (if_id_pc4 !== m_pc4) begin
                errors++; $display("FAIL rnd_pc4 got=%h exp=%h", if_id_pc4, m_pc4);
            end
            if (if_id_valid !== m_valid) begin
                errors++; $display("FAIL rnd_valid got=%b exp=%b", if_id_valid, m_valid);
            end
            if (misalign !== m_mis) begin
                errors++; $display("FAIL rnd_mis got=%b exp=%b", misalign, m_mis);
            end
            if (fetch_count !== m_cnt) begin
                errors++; $display("FAIL rnd_cnt got=%0d exp=%0d", fetch_count, m_cnt);
            end
        end
    endtask

    task automatic test_wrap();
        rst_w = 1'b1;
        @(posedge clk); #1;
        rst_w = 1'b0;
        checks++;
        if (addr_w !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_rst_addr got=%h exp=fffffffc", addr_w);
        end
        @(posedge clk); #1;
        checks += 3;
        if (addr_w !== 32'h0) begin
            errors++; $display("FAIL wrap_addr got=%h exp=0", addr_w);
        end
        if (pc4_w !== 32'h0 || valid_w !== 1'b1) begin
            errors++; $display("FAIL wrap_pc4 got=%h/%b exp=0/1", pc4_w, valid_w);
        end
        if (instr_w !== 32'h5FFF_FFFF || mis_w !== 1'b0) begin
            errors++;
            $display("FAIL wrap_instr got=%h/%b exp=5fffffff/0", instr_w, mis_w);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_flush();
        test_misalign();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
